// File: rtl/serial_adder_acc_if.sv
// Handshake bundle for serial_adder_acc: operand request channel and result channel.
// The producer/consumer side takes the master modport, the adder takes slave.
interface serial_adder_acc_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             acc_en;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, acc_en, acc_clr, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, acc_en, acc_clr, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );
endinterface

// File: rtl/serial_adder_acc.sv
// Digit-serial add/subtract unit with optional accumulate: one DIGIT-bit ripple
// slice is reused for WIDTH/DIGIT cycles, trading latency for area.
module serial_adder_acc #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_adder_acc_if.slave bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if ((WIDTH % DIGIT) != 0 || N < 1) begin : g_bad_params
        $error("serial_adder_acc: WIDTH must be a positive multiple of DIGIT");
    end

    // Bit-level ripple of full-adder cells; returns {carry_out, sum}.
    function automatic logic [DIGIT:0] ripple_add(
        input logic [DIGIT-1:0] x,
        input logic [DIGIT-1:0] y,
        input logic             c_in
    );
        logic             c;
        logic [DIGIT-1:0] sum;
        c = c_in;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i] = x[i] ^ y[i] ^ c;
            c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, sum};
    endfunction

    // Two's-complement overflow: like-signed operands giving an unlike-signed result.
    function automatic logic signed_ovf(
        input logic a_msb,
        input logic b_msb,
        input logic s_msb
    );
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    logic [1:0]       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic             carry_q;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             ovf_q;
    logic [WIDTH-1:0] acc_q;

    logic             accept;
    logic             last_digit;
    logic [WIDTH-1:0] acc_src;
    int               lsb;
    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;
    logic [DIGIT:0]   slice;

    always_comb begin
        accept     = bus.in_valid & in_ready_q & (state_q == IDLE);
        last_digit = (cnt_q == LAST);
        // A clear coinciding with an accept wins, so accumulation starts from zero.
        acc_src    = bus.acc_clr ? '0 : acc_q;
        lsb        = int'(cnt_q) * DIGIT;
        dig_a      = op_a_q[lsb +: DIGIT];
        dig_b      = op_b_q[lsb +: DIGIT];
        slice      = ripple_add(dig_a, dig_b, carry_q);
    end

    // Control: state, digit counter and both handshake flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q    <= CALC;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (last_digit) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: operand latch, digit-serial sum, flags and accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            acc_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.acc_clr) begin
                        acc_q <= '0;
                    end
                    if (accept) begin
                        op_a_q  <= bus.acc_en ? acc_src : bus.a;
                        op_b_q  <= bus.sub ? ~bus.b : bus.b;
                        carry_q <= bus.sub | bus.cin;
                    end
                end
                CALC: begin
                    s_q[lsb +: DIGIT] <= slice[DIGIT-1:0];
                    carry_q           <= slice[DIGIT];
                    if (last_digit) begin
                        cout_q <= slice[DIGIT];
                        ovf_q  <= signed_ovf(op_a_q[WIDTH-1], op_b_q[WIDTH-1], slice[DIGIT-1]);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        acc_q <= s_q;
                    end
                end
                default: begin
                    carry_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.s         = s_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder_acc.sv
// Scoreboard bench for serial_adder_acc: directed vectors, accumulate, backpressure,
// mid-operation reset and a short random run.
module tb_serial_adder_acc;
    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int N     = WIDTH / DIGIT;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    serial_adder_acc_if #(.WIDTH(WIDTH)) bus();

    serial_adder_acc #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             cout;
        logic             ovf;
    } exp_t;

    exp_t             sb[$];
    exp_t             mon_e;
    logic [WIDTH-1:0] tb_acc = '0;
    int               n_checks = 0;
    int               n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [WIDTH-1:0] s, input logic c, input logic o);
        exp_t r;
        r.s    = s;
        r.cout = c;
        r.ovf  = o;
        return r;
    endfunction

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub, input logic acc_en,
                                   input logic [WIDTH-1:0] acc);
        logic [WIDTH-1:0] opa, opb;
        logic [WIDTH:0]   full;
        opa  = acc_en ? acc : a;
        opb  = sub ? ~b : b;
        full = {1'b0, opa} + {1'b0, opb} + (WIDTH+1)'(sub | cin);
        return mk(full[WIDTH-1:0], full[WIDTH],
                  (opa[WIDTH-1] == opb[WIDTH-1]) && (full[WIDTH-1] != opa[WIDTH-1]));
    endfunction

    // Results are compared as they leave the DUT.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            check("sb_pending", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("s", 32'(bus.s), 32'(mon_e.s));
                check("cout", 32'(bus.cout), 32'(mon_e.cout));
                check("ovf", 32'(bus.ovf), 32'(mon_e.ovf));
            end
        end
    end

    task automatic drive_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic cin, input logic sub, input logic acc_en,
                            input logic acc_clr, input exp_t e);
        int w = 0;
        while (!bus.in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (!bus.in_ready) begin
            check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
            return;
        end
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        bus.acc_en   = acc_en;
        bus.acc_clr  = acc_clr;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.acc_clr  = 1'b0;
        sb.push_back(e);
        tb_acc = e.s;
    endtask

    task automatic wait_out(input int exp_lat);
        int cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 32'(cyc), 32'(exp_lat));
    endtask

    task automatic drain();
        int w = 0;
        while (bus.out_valid && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check("drained", 32'(bus.out_valid), 32'd0);
    endtask

    task automatic op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin, input logic sub, input logic acc_en,
                      input logic acc_clr, input exp_t e);
        drive_op(a, b, cin, sub, acc_en, acc_clr, e);
        wait_out(N);
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic             rc, rs, re;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.acc_en    = 1'b0;
        bus.acc_clr   = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_s", 32'(bus.s), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Directed add / carry / subtract vectors
        op(16'h00B4, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b0, mk(16'h00F4, 1'b0, 1'b0));
        op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0));
        op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1));
        op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 1'b0, mk(16'hFFFE, 1'b0, 1'b0));
        op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, mk(16'h7FFF, 1'b1, 1'b1));
        op(16'h1234, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, mk(16'h1236, 1'b0, 1'b0));

        // Accumulate: clear, then three acc_en ops; a is junk and must be ignored
        bus.acc_clr = 1'b1;
        @(posedge clk); #1;
        bus.acc_clr = 1'b0;
        tb_acc = '0;
        op(16'hDEAD, 16'h0010, 1'b0, 1'b0, 1'b1, 1'b0, mk(16'h0010, 1'b0, 1'b0));
        drive_op(16'hDEAD, 16'h0020, 1'b0, 1'b0, 1'b1, 1'b0, mk(16'h0030, 1'b0, 1'b0));
        // in_valid and acc_clr while busy must both be ignored
        bus.a        = 16'h1111;
        bus.acc_en   = 1'b0;
        bus.acc_clr  = 1'b1;
        bus.in_valid = 1'b1;
        check("busy_in_ready0", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        check("busy_in_ready1", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        bus.acc_clr  = 1'b0;
        wait_out(N - 1);
        drain();
        op(16'hDEAD, 16'h0030, 1'b0, 1'b0, 1'b1, 1'b0, mk(16'h0060, 1'b0, 1'b0));
        // Clear coinciding with accept: accumulation starts from zero
        op(16'hDEAD, 16'h0005, 1'b0, 1'b0, 1'b1, 1'b1, mk(16'h0005, 1'b0, 1'b0));

        // Backpressure: result held for 10 cycles, then exactly one transfer
        bus.out_ready = 1'b0;
        drive_op(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, mk(16'h2345, 1'b0, 1'b0));
        wait_out(N);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_s", 32'(bus.s), 32'h2345);
            check("bp_flags", 32'({bus.cout, bus.ovf}), 32'd0);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_ready", 32'(bus.in_ready), 32'd1);
        check("bp_sb_empty", 32'(sb.size()), 32'd0);

        // Asynchronous reset during the second CALC cycle
        drive_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 1'b0, mk(16'h5555, 1'b0, 1'b0));
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_s", 32'(bus.s), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        sb.delete();
        tb_acc = '0;
        @(posedge clk); #1;
        check("mid_rst_hold_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_release_ready", 32'(bus.in_ready), 32'd1);
        // Accumulator must be zero: acc_en + 9 gives 9
        op(16'hFFFF, 16'h0009, 1'b0, 1'b0, 1'b1, 1'b0, mk(16'h0009, 1'b0, 1'b0));
        op(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0, mk(16'h0007, 1'b0, 1'b0));

        // Random operations against the arithmetic model
        for (int i = 0; i < 20; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            re = 1'($urandom);
            op(ra, rb, rc, rs, re, 1'b0, model(ra, rb, rc, rs, re, tb_acc));
        end

        check("sb_empty_end", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/serial_adder_acc.md
Name: serial_adder_acc

Overview:
- Parametrised multi-cycle successor to the team's 4-bit ripple-carry adder.
- Adds or subtracts two WIDTH-bit operands using one full-adder slice per cycle, DIGIT bits at a time, with a valid/ready handshake.
- Optional accumulate mode feeds the previous result back as operand A.
- Sits in the arithmetic datapath wherever area matters more than latency.

Parameters:
- WIDTH, 16: operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 4: bits processed per cycle (ripple slice width).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands presented
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A (ignored when acc_en=1)
- b  input  WIDTH  operand B
- cin  input  1  carry-in (forced to 1 internally when sub=1)
- sub  input  1  1 = a - b (two's complement), 0 = a + b
- acc_en  input  1  1 = use stored result as operand A
- acc_clr  input  1  synchronous clear of the stored accumulator, honoured only in IDLE
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- s  output  WIDTH  sum/difference
- cout  output  1  carry-out of MSB slice
- ovf  output  1  signed overflow

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, in_ready=0 during reset and 1 on the first cycle after release.
  - out_valid=0, s=0, cout=0, ovf=0, accumulator=0, digit counter=0.
- States: IDLE, CALC, DONE. N = WIDTH/DIGIT.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready, latch the following and go to CALC:
    - opA = acc_en ? accumulator : a
    - opB = sub ? ~b : b
    - carry = sub ? 1 : cin
    - counter = 0
  - acc_clr=1 in IDLE sets the accumulator to 0 at the same edge. If accept and acc_clr coincide, acc_clr applies first, so acc_en uses 0.
- CALC:
  - in_ready=0.
  - Each cycle, add digit[counter] of opA and opB plus carry through a DIGIT-bit ripple.
  - Write the result digit into s, update carry, and increment counter.
  - Once the last digit (counter = N-1) is written, go to DONE. Total latency from accept to out_valid = N cycles (default 4).
- DONE:
  - out_valid=1.
  - s, cout and ovf are held stable until out_ready=1.
  - ovf = (opA[MSB] == opB[MSB]) & (s[MSB] != opA[MSB]), using the post-inversion opB.
  - cout is the raw final carry. For subtraction, cout=1 means no borrow.
  - On out_valid & out_ready: accumulator <= s, out_valid drops next cycle, return to IDLE.
  - in_ready stays 0 in DONE, so there is no overlap between operations.
- Boundary rules:
  - in_valid held while busy: ignored, not queued.
  - out_ready held high in DONE: single-cycle out_valid pulse.
  - acc_clr outside IDLE: ignored.
  - Reset asserted mid-CALC or in DONE: operation is abandoned and all outputs and the accumulator return to their reset values.
  - Wrap-around: results are modulo 2^WIDTH, reported only through cout/ovf.
- Throughput: one result per N+2 cycles at best (accept, N compute cycles including the transition into DONE, handshake).

Test Plan:
- Basic add: a=16'h00B4, b=16'h0040, cin=0, sub=0 -> after 4 cycles out_valid=1, s=16'h00F4, cout=0, ovf=0.
- Carry chain across all digits: a=16'hFFFF, b=16'h0001, cin=0 -> s=16'h0000, cout=1, ovf=0. Also a=16'h7FFF, b=16'h0001 -> s=16'h8000, ovf=1.
- Subtract: a=16'h0005, b=16'h0007, sub=1 -> s=16'hFFFE, cout=0 (borrow), ovf=0. Then a=16'h8000, b=16'h0001, sub=1 -> s=16'h7FFF, ovf=1.
- Accumulate:
  - acc_clr pulse in IDLE.
  - Three ops with acc_en=1, b=16'h0010, 16'h0020, 16'h0030 -> s=16'h0010, then 16'h0030, then 16'h0060.
  - in_valid asserted during CALC is not accepted (in_ready=0).
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> s, cout, ovf and out_valid stay stable and in_ready stays 0. Raise out_ready -> exactly one transfer, IDLE on the next cycle.
- Reset mid-operation: assert rst_n=0 asynchronously (between clock edges) during the 2nd CALC cycle -> out_valid, s and the accumulator are 0 immediately, in_ready=0 during reset then 1 after release. A following add of a=16'h0003, b=16'h0004 returns s=16'h0007.
